// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps fill-left/right/both-ends/centre patterns on a divided enable tick.
// Define LED_SEQ_STATUS_EN to add the pat/done status outputs; led behaviour is identical either way.
module led_pattern_seq #(
  parameter int LED_W = 12,
  parameter int DIV   = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mode,
  input  logic [2:0]       sel,
  output logic [LED_W-1:0] led
`ifdef LED_SEQ_STATUS_EN
  ,
  output logic [2:0]       pat,
  output logic             done
`endif
);

  localparam int H  = LED_W / 2;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(DIV - 1);
  localparam logic [LED_W-1:0] ALL_ONES = '1;
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] LED_MSB  = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [H-1:0]     HALF_ONE = H'(1);
  localparam logic [H-1:0]     HALF_MSB = {1'b1, {(H-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL_L = 3'd1,
    S_FILL_R = 3'd2,
    S_FILL_B = 3'd3,
    S_FILL_C = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [LED_W-1:0] led_nxt;
  logic [CW-1:0]    cnt;
  logic             tick;

  assign tick = run && (cnt == CNT_MAX);

  function automatic state_t pattern_of(input logic [2:0] s);
    case (s)
      3'd1:    return S_FILL_L;
      3'd2:    return S_FILL_R;
      3'd3:    return S_FILL_B;
      3'd4:    return S_FILL_C;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic state_t successor(input state_t s);
    case (s)
      S_IDLE:   return S_FILL_L;
      S_FILL_L: return S_FILL_R;
      S_FILL_R: return S_FILL_B;
      S_FILL_B: return S_FILL_C;
      default:  return S_IDLE;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] first_val(input state_t s);
    case (s)
      S_FILL_L: return LED_ONE;
      S_FILL_R: return LED_MSB;
      S_FILL_B: return LED_MSB | LED_ONE;
      S_FILL_C: return {HALF_ONE, HALF_MSB};
      default:  return '0;
    endcase
  endfunction

  // Partial-fill step only; the empty and full cases are handled by the caller.
  function automatic logic [LED_W-1:0] step_val(input state_t s, input logic [LED_W-1:0] l);
    logic [H-1:0] up, dn;
    up = l[LED_W-1:H];
    dn = l[H-1:0];
    case (s)
      S_FILL_L: return (l << 1) | LED_ONE;
      S_FILL_R: return (l >> 1) | LED_MSB;
      S_FILL_B: return (l >> 1) | LED_MSB | (l << 1) | LED_ONE;
      S_FILL_C: return {(up << 1) | HALF_ONE, (dn >> 1) | HALF_MSB};
      default:  return '0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      led   <= '0;
    end else begin
      state <= state_nxt;
      led   <= led_nxt;
    end
  end

  // NOTE: defaults assigned first so no path leaves a combinational output unassigned (no latches).
  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    if (tick) begin
      case (state)
        S_IDLE, S_FILL_L, S_FILL_R, S_FILL_B, S_FILL_C: begin
          if (led == '0) begin
            state_nxt = mode ? pattern_of(sel) : successor(state);
            led_nxt   = first_val(state_nxt);
          end else if (led == ALL_ONES) begin
            led_nxt = '0;
          end else begin
            led_nxt = step_val(state, led);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          led_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LED_SEQ_STATUS_EN
  logic done_nxt;

  always_comb begin
    done_nxt = tick && (led == ALL_ONES) && (state inside {S_FILL_L, S_FILL_R, S_FILL_B, S_FILL_C});
    pat      = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= done_nxt;
    end
  end
`endif

endmodule
